rom_reader: RTL and testbench

Initiator-side sequencer for the combinational lookup ROM interface (addr/ce/ren in, data out). On a start command it sweeps a contiguous address window, driving ce/ren/addr and capturing the returned words. Captured words go into a small output FIFO with a valid/ready stream, and the block keeps a running sum. It sits between a control master and any downstream consumer of table data.

---
 rtl/rom_reader_pkg.sv | 17 +
 rtl/rom_reader_sync_fifo.sv | 58 +++++
 rtl/rom_reader.sv | 120 ++++++++++++
 tb/tb_rom_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_reader_pkg.sv
// Shared types and default widths for the ROM sweep reader.
// Imported by rom_reader and its output FIFO.
package rom_reader_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_SUM_WIDTH  = DEF_DATA_WIDTH + DEF_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_reader_sync_fifo.sv
// Small synchronous FIFO with head-of-queue read port.
// Head data reads as zero while empty.
module sync_fifo
    import rom_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PW = $clog2(FIFO_DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count,
    output logic [DATA_WIDTH-1:0] o_head
);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + CW'(1);
            end else if (i_pop && !i_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign o_full  = (r_count == CW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/rom_reader.sv
// Sweeps a ROM address window, streams the words out through a
// FIFO and keeps a running sum of everything read.
module rom_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SUM_WIDTH  = DATA_WIDTH + ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [SUM_WIDTH-1:0]  sum,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic                  rom_ce,
    output logic                  rom_ren,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [SUM_WIDTH-1:0]  r_sum;
    logic                  w_rd;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [DATA_WIDTH-1:0] w_head;
    logic                  w_accept;

    assign w_accept = (r_state == IDLE) && start;
    assign w_pop    = !w_empty && out_ready;

    always_comb begin
        w_next = r_state;
        w_rd   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (length == '0) ? DONE : READ;
                end
            end
            READ: begin
                w_rd = !w_full;
                if (w_rd && r_remaining == (ADDR_WIDTH+1)'(1)) begin
                    w_next = DRAIN;
                end
            end
            // Leave as the last word pops so done lands the next cycle.
            DRAIN: begin
                if (w_empty || (w_count == CW'(1) && w_pop)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
            r_sum       <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_cur_addr  <= base_addr;
                r_remaining <= length;
                r_sum       <= '0;
            end else if (w_rd) begin
                r_cur_addr  <= r_cur_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - (ADDR_WIDTH+1)'(1);
                r_sum       <= r_sum + SUM_WIDTH'(rom_data);
            end
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .i_push      (w_rd),
        .i_push_data (rom_data),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign busy      = (r_state == READ) || (r_state == DRAIN);
    assign done      = (r_state == DONE);
    assign sum       = r_sum;
    assign rom_addr  = r_cur_addr;
    assign rom_ce    = w_rd;
    assign rom_ren   = w_rd;
    assign out_data  = w_head;
    assign out_valid = !w_empty;

endmodule

// File: tb/tb_rom_reader.sv
// Directed bench for rom_reader with a 32-entry ROM holding 32-addr.
// Expected words, addresses and sums are hand-computed constants.
module tb_rom_reader;

    localparam int AW = 5;
    localparam int DW = 8;
    localparam int SW = DW + AW + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [SW-1:0] sum;
    logic [AW-1:0] rom_addr;
    logic          rom_ce;
    logic          rom_ren;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    int q_addr[$];
    int q_data[$];
    int exp_addr[$];
    int exp_data[$];
    int n_done;
    int n_ren_bad;

    always #5 clk = ~clk;

    assign rom_data = DW'(32 - int'(rom_addr));

    rom_reader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .rom_addr  (rom_addr),
        .rom_ce    (rom_ce),
        .rom_ren   (rom_ren),
        .rom_data  (rom_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int b, input int l);
        start     = 1'b1;
        base_addr = AW'(b);
        length    = (AW+1)'(l);
        tick();
        start     = 1'b0;
    endtask

    // Runs until done (plus a tail), logging reads, pops and done pulses.
    task automatic collect(input int restart_at);
        bit seen = 0;
        int tail = 0;
        q_addr.delete();
        q_data.delete();
        n_done    = 0;
        n_ren_bad = 0;
        for (int i = 0; i < 80 && tail < 3; i++) begin
            if (rom_ce) q_addr.push_back(int'(rom_addr));
            if (rom_ren != rom_ce) n_ren_bad++;
            if (out_valid && out_ready) q_data.push_back(int'(out_data));
            if (done) begin
                n_done++;
                seen = 1;
            end
            if (seen) tail++;
            start = (i == restart_at);
            if (i == restart_at) begin
                base_addr = AW'(10);
                length    = (AW+1)'(4);
            end
            tick();
        end
        start = 1'b0;
        check("done_seen", int'(seen), 1);
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_nwords"}, q_data.size(), exp_data.size());
        for (int k = 0; k < exp_data.size() && k < q_data.size(); k++)
            check({tag, "_word"}, q_data[k], exp_data[k]);
        check({tag, "_nreads"}, q_addr.size(), exp_addr.size());
        for (int k = 0; k < exp_addr.size() && k < q_addr.size(); k++)
            check({tag, "_addr"}, q_addr[k], exp_addr[k]);
        check({tag, "_ndone"}, n_done, 1);
        check({tag, "_ren"}, n_ren_bad, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_ce"}, int'(rom_ce), 0);
        check({tag, "_ren"}, int'(rom_ren), 0);
        check({tag, "_valid"}, int'(out_valid), 0);
        check({tag, "_addr"}, int'(rom_addr), 0);
        check({tag, "_sum"}, int'(sum), 0);
        check({tag, "_data"}, int'(out_data), 0);
    endtask

    int t1_ce[6]    = '{1, 1, 1, 1, 0, 0};
    int t1_valid[6] = '{0, 1, 1, 1, 1, 0};
    int t1_done[6]  = '{0, 0, 0, 0, 0, 1};
    int t1_busy[6]  = '{1, 1, 1, 1, 1, 0};
    int t1_data[6]  = '{0, 32, 31, 30, 29, 0};
    int n_rd;

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check_idle_outputs("rst");
        resetn = 1'b1;
        tick();
        check_idle_outputs("post_rst");

        // Basic sweep, cycle by cycle.
        do_start(0, 4);
        for (int c = 0; c < 6; c++) begin
            check("t1_ce", int'(rom_ce), t1_ce[c]);
            if (t1_ce[c] == 1) check("t1_addr", int'(rom_addr), c);
            check("t1_valid", int'(out_valid), t1_valid[c]);
            if (t1_valid[c] == 1) check("t1_data", int'(out_data), t1_data[c]);
            check("t1_done", int'(done), t1_done[c]);
            check("t1_busy", int'(busy), t1_busy[c]);
            tick();
        end
        check("t1_done_end", int'(done), 0);
        check("t1_sum", int'(sum), 122);

        // Zero length.
        do_start(7, 0);
        check("t2_done", int'(done), 1);
        check("t2_busy", int'(busy), 0);
        check("t2_ce", int'(rom_ce), 0);
        check("t2_valid", int'(out_valid), 0);
        check("t2_sum", int'(sum), 0);
        tick();
        check("t2_done_end", int'(done), 0);
        check("t2_ce_end", int'(rom_ce), 0);

        // Backpressure fills the FIFO, then drain.
        out_ready = 1'b0;
        do_start(0, 8);
        n_rd = 0;
        for (int c = 1; c <= 6; c++) begin
            if (rom_ce) n_rd++;
            if (c >= 5) begin
                check("t3_ce_full", int'(rom_ce), 0);
                check("t3_addr_hold", int'(rom_addr), 4);
                check("t3_head", int'(out_data), 32);
                check("t3_busy", int'(busy), 1);
            end
            tick();
        end
        check("t3_reads", n_rd, 4);
        out_ready = 1'b1;
        collect(-1);
        exp_data = '{32, 31, 30, 29, 28, 27, 26, 25};
        exp_addr = '{4, 5, 6, 7};
        compare_q("t3");
        check("t3_sum", int'(sum), 228);

        // Address wrap.
        do_start(30, 4);
        collect(-1);
        exp_data = '{2, 1, 32, 31};
        exp_addr = '{30, 31, 0, 1};
        compare_q("t4");
        check("t4_sum", int'(sum), 66);

        // Start while busy is ignored.
        do_start(0, 4);
        collect(1);
        exp_data = '{32, 31, 30, 29};
        exp_addr = '{0, 1, 2, 3};
        compare_q("t5");
        check("t5_sum", int'(sum), 122);

        // Reset in the middle of a sweep.
        do_start(0, 8);
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check_idle_outputs("t6_rst");
        tick();
        check("t6_done_rst", int'(done), 0);
        resetn = 1'b1;
        tick();
        check("t6_done_rel", int'(done), 0);
        check("t6_valid_rel", int'(out_valid), 0);
        do_start(5, 2);
        collect(-1);
        exp_data = '{27, 26};
        exp_addr = '{5, 6};
        compare_q("t6");
        check("t6_sum", int'(sum), 53);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
